// File: rtl/max7219_pkg.sv
// Shared definitions for the MAX7219 serial interface: FSM state type,
// frame width and the device register address map.
package max7219_pkg;

    // Frame width of one MAX7219 transfer: [15:8] address, [7:0] data.
    localparam int C_MAX7219_FRAME_W = 16;

    // Serializer FSM states.
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLK_LOW,
        ST_CLK_HIGH,
        ST_LATCH,
        ST_DONE
    } t_max7219_if_state;

    // MAX7219 register addresses (low nibble of the address byte).
    localparam logic [3:0] C_REG_NOOP         = 4'h0;
    localparam logic [3:0] C_REG_DIGIT0       = 4'h1;
    localparam logic [3:0] C_REG_DIGIT1       = 4'h2;
    localparam logic [3:0] C_REG_DIGIT2       = 4'h3;
    localparam logic [3:0] C_REG_DIGIT3       = 4'h4;
    localparam logic [3:0] C_REG_DIGIT4       = 4'h5;
    localparam logic [3:0] C_REG_DIGIT5       = 4'h6;
    localparam logic [3:0] C_REG_DIGIT6       = 4'h7;
    localparam logic [3:0] C_REG_DIGIT7       = 4'h8;
    localparam logic [3:0] C_REG_DECODE_MODE  = 4'h9;
    localparam logic [3:0] C_REG_INTENSITY    = 4'hA;
    localparam logic [3:0] C_REG_SCAN_LIMIT   = 4'hB;
    localparam logic [3:0] C_REG_SHUTDOWN     = 4'hC;
    localparam logic [3:0] C_REG_DISPLAY_TEST = 4'hF;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/max7219_half_period_cnt.sv
// Half-period timer for the MAX7219 serializer. Counts clk cycles since the
// last restart and raises tick on the G_HALF_PERIOD-th cycle of a phase.
module max7219_half_period_cnt
    import max7219_pkg::*;
#(
    parameter int G_HALF_PERIOD = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    output logic tick
);

    localparam int C_CNT_W = cnt_width(G_HALF_PERIOD);
    localparam logic [C_CNT_W-1:0] C_LAST = C_CNT_W'(G_HALF_PERIOD - 1);

    logic [C_CNT_W-1:0] cnt_reg;

    // Free-running phase counter, cleared whenever the owner starts a new phase.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_reg <= '0;
        end else if (restart) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_reg + C_CNT_W'(1);
        end
    end

    assign tick = (cnt_reg == C_LAST);

endmodule

// File: rtl/max7219_serial_if.sv
// MAX7219 physical-side serializer. Takes one frame per start request,
// shifts it MSB-first on DIN/CLK, optionally pulses LOAD high afterwards to
// latch it, and returns a one-cycle done pulse.
// Optional build macro MAX7219_SERIAL_IF_START_ERR_EN adds o_start_err, a
// one-cycle flag for a start request seen while the block is busy.
module max7219_serial_if
    import max7219_pkg::*;
#(
    parameter int G_HALF_PERIOD = 2,
    parameter int G_DATA_WIDTH  = C_MAX7219_FRAME_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_en,
    input  logic                    i_start,
    input  logic                    i_en_load,
    input  logic [G_DATA_WIDTH-1:0] i_data,
    output logic                    o_done,
    output logic                    o_busy,
    output logic                    o_max7219_clk,
    output logic                    o_max7219_din,
    output logic                    o_max7219_load
`ifdef MAX7219_SERIAL_IF_START_ERR_EN
    ,
    output logic                    o_start_err
`endif
);

    localparam int C_IDX_W = $clog2(G_DATA_WIDTH);
    localparam logic [C_IDX_W-1:0] C_IDX_MSB = C_IDX_W'(G_DATA_WIDTH - 1);

    t_max7219_if_state       state_reg;
    logic [G_DATA_WIDTH-1:0] shift_reg;
    logic [C_IDX_W-1:0]      idx_reg;
    logic [C_IDX_W-1:0]      idx_next;
    logic                    en_load_reg;
    logic                    tick;
    logic                    restart;

    // Every timed phase ends on tick, and IDLE/DONE are untimed, so clearing
    // on those conditions restarts the count on every state entry.
    assign restart  = (state_reg == ST_IDLE) || (state_reg == ST_DONE) || tick;
    assign idx_next = idx_reg - C_IDX_W'(1);

    max7219_half_period_cnt #(
        .G_HALF_PERIOD (G_HALF_PERIOD)
    ) u_half_period_cnt (
        .clk     (clk),
        .rst     (rst),
        .restart (restart),
        .tick    (tick)
    );

    // Serializer FSM with all pin-side outputs registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= ST_IDLE;
            shift_reg      <= '0;
            idx_reg        <= C_IDX_MSB;
            en_load_reg    <= 1'b0;
            o_done         <= 1'b0;
            o_busy         <= 1'b0;
            o_max7219_clk  <= 1'b0;
            o_max7219_din  <= 1'b0;
            o_max7219_load <= 1'b1;
        end else begin
            o_done <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (i_en && i_start) begin
                        shift_reg      <= i_data;
                        en_load_reg    <= i_en_load;
                        idx_reg        <= C_IDX_MSB;
                        o_max7219_load <= 1'b0;
                        o_max7219_clk  <= 1'b0;
                        o_max7219_din  <= i_data[G_DATA_WIDTH-1];
                        o_busy         <= 1'b1;
                        state_reg      <= ST_CLK_LOW;
                    end
                end
                ST_CLK_LOW: begin
                    // Rising edge here is where the device samples DIN.
                    if (tick) begin
                        o_max7219_clk <= 1'b1;
                        state_reg     <= ST_CLK_HIGH;
                    end
                end
                ST_CLK_HIGH: begin
                    if (tick) begin
                        o_max7219_clk <= 1'b0;
                        if (idx_reg != '0) begin
                            idx_reg       <= idx_next;
                            o_max7219_din <= shift_reg[idx_next];
                            state_reg     <= ST_CLK_LOW;
                        end else if (en_load_reg) begin
                            state_reg <= ST_LATCH;
                        end else begin
                            // LOAD stays low so a following frame can chain.
                            o_done    <= 1'b1;
                            state_reg <= ST_DONE;
                        end
                    end
                end
                ST_LATCH: begin
                    // LOAD hold time after the final CLK fall, then latch.
                    if (tick) begin
                        o_max7219_load <= 1'b1;
                        o_done         <= 1'b1;
                        state_reg      <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    o_busy    <= 1'b0;
                    state_reg <= ST_IDLE;
                end
                default: begin
                    o_busy    <= 1'b0;
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef MAX7219_SERIAL_IF_START_ERR_EN
    // Flag a start request that arrives while a frame is still in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_start_err <= 1'b0;
        end else begin
            o_start_err <= i_start && o_busy;
        end
    end
`endif

endmodule

// File: tb/tb_max7219_serial_if.sv
// Self-checking bench for max7219_serial_if: a timing-formula model of the
// serial waveform checked every cycle, plus directed frames with literal
// expectations and a randomized phase.
module tb_max7219_serial_if;

    localparam int H  = 2;
    localparam int H1 = 1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic        start = 1'b0;
    logic        start1 = 1'b0;
    logic        en_load = 1'b0;
    logic [15:0] data = 16'h0000;

    logic d_done, d_busy, d_clk, d_din, d_load;
    logic h1_done, h1_busy, h1_clk, h1_din, h1_load;
`ifdef MAX7219_SERIAL_IF_START_ERR_EN
    logic d_start_err, h1_start_err;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    max7219_serial_if #(.G_HALF_PERIOD(H), .G_DATA_WIDTH(16)) u_dut (
        .clk            (clk),
        .rst            (rst),
        .i_en           (en),
        .i_start        (start),
        .i_en_load      (en_load),
        .i_data         (data),
        .o_done         (d_done),
        .o_busy         (d_busy),
        .o_max7219_clk  (d_clk),
        .o_max7219_din  (d_din),
        .o_max7219_load (d_load)
`ifdef MAX7219_SERIAL_IF_START_ERR_EN
        ,
        .o_start_err    (d_start_err)
`endif
    );

    max7219_serial_if #(.G_HALF_PERIOD(H1), .G_DATA_WIDTH(16)) u_dut_h1 (
        .clk            (clk),
        .rst            (rst),
        .i_en           (en),
        .i_start        (start1),
        .i_en_load      (en_load),
        .i_data         (data),
        .o_done         (h1_done),
        .o_busy         (h1_busy),
        .o_max7219_clk  (h1_clk),
        .o_max7219_din  (h1_din),
        .o_max7219_load (h1_load)
`ifdef MAX7219_SERIAL_IF_START_ERR_EN
        ,
        .o_start_err    (h1_start_err)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Reference model: for a frame accepted at edge t0, the outputs after edge
    // t0+k follow directly from k (2H cycles per bit, optional H-cycle latch).
    int          cyc = 0;
    int          t0 = 0;
    int          k = 0;
    int          lat_l = 0;
    bit          active = 1'b0;
    logic [15:0] fd = 16'h0;
    bit          fl = 1'b0;
    logic m_clk = 1'b0, m_din = 1'b0, m_load = 1'b1, m_busy = 1'b0, m_done = 1'b0;

    initial forever begin
        @(posedge clk);
        cyc++;
        if (rst) begin
            active = 1'b0;
            m_clk = 1'b0; m_din = 1'b0; m_load = 1'b1; m_busy = 1'b0; m_done = 1'b0;
        end else begin
            if (!m_busy && en && start) begin
                active = 1'b1; t0 = cyc; fd = data; fl = en_load;
            end
            if (active) begin
                k     = cyc - t0;
                lat_l = fl ? H : 0;
                m_busy = (k <= 32*H + lat_l);
                m_done = (k == 32*H + lat_l);
                if (k < 32*H) begin
                    m_clk = ((k % (2*H)) >= H);
                    m_din = fd[15 - k/(2*H)];
                end else begin
                    m_clk = 1'b0;
                end
                m_load = (fl && k >= 33*H);
                if (k > 32*H + lat_l) active = 1'b0;
            end
        end
    end

    // Every-cycle comparison of the H=2 instance against the model.
    initial forever begin
        @(posedge clk);
        #1;
        chk($sformatf("cyc%0d_{clk,din,load,busy,done}", cyc),
            32'({d_clk, d_din, d_load, d_busy, d_done}),
            32'({m_clk, m_din, m_load, m_busy, m_done}));
    end

    // Drive one frame and measure it; latencies are counted in the
    // "sampled at edge t0+n" sense (lat=1 is the first edge after t0).
    task automatic run_frame(input logic [15:0] d, input logic el, input bit use_h1,
                             input int inject_at, output int lat_done,
                             output int lat_load_rise, output logic [15:0] bits,
                             output int nrise, output int load_rises,
                             output logic load_at1, output int err_pulses);
        logic pc, pl, sc, sd, sl, sdn;
        int   lat;
        @(negedge clk);
        pc = use_h1 ? h1_clk : d_clk;
        pl = use_h1 ? h1_load : d_load;
        data = d; en_load = el; en = 1'b1;
        if (use_h1) start1 = 1'b1; else start = 1'b1;
        lat_done = -1; lat_load_rise = -1; bits = 16'h0; nrise = 0;
        load_rises = 0; load_at1 = 1'b1; err_pulses = 0;
        @(negedge clk);
        start = 1'b0; start1 = 1'b0;
        lat = 1;
        while (lat <= 200) begin
            sc  = use_h1 ? h1_clk  : d_clk;
            sd  = use_h1 ? h1_din  : d_din;
            sl  = use_h1 ? h1_load : d_load;
            sdn = use_h1 ? h1_done : d_done;
            if (lat == 1) load_at1 = sl;
            if (sc && !pc) begin bits = {bits[14:0], sd}; nrise++; end
            if (sl && !pl) begin
                load_rises++;
                if (lat_load_rise < 0) lat_load_rise = lat;
            end
`ifdef MAX7219_SERIAL_IF_START_ERR_EN
            if (!use_h1 && d_start_err) err_pulses++;
`endif
            pc = sc; pl = sl;
            if (inject_at > 0 && lat == inject_at) begin start = 1'b1; data = 16'hFFFF; end
            if (inject_at > 0 && lat == inject_at + 1) start = 1'b0;
            if (sdn) begin lat_done = lat; break; end
            @(negedge clk);
            lat++;
        end
    endtask

    int          r_done, r_lrise, r_nrise, r_lrises, r_err;
    logic [15:0] r_bits;
    logic        r_l1;

    initial begin
        // Reset and idle hold.
        repeat (3) @(negedge clk);
        chk("reset_state{clk,din,load,busy,done}", 32'({d_clk, d_din, d_load, d_busy, d_done}), 32'(5'b00100));
        chk("reset_state_h1", 32'({h1_clk, h1_din, h1_load, h1_busy, h1_done}), 32'(5'b00100));
        rst = 1'b0; en = 1'b1;
        repeat (5) @(negedge clk);
        chk("idle_hold{clk,din,load,busy,done}", 32'({d_clk, d_din, d_load, d_busy, d_done}), 32'(5'b00100));

        // Latched frame 0x0C01.
        run_frame(16'h0C01, 1'b1, 1'b0, -1, r_done, r_lrise, r_bits, r_nrise, r_lrises, r_l1, r_err);
        chk("latched_bits", 32'(r_bits), 32'h0C01);
        chk("latched_clk_rises", 32'(r_nrise), 32'd16);
        chk("latched_load_low_t0p1", 32'(r_l1), 32'd0);
        chk("latched_load_rise_lat", 32'(r_lrise), 32'd67);
        chk("latched_done_lat", 32'(r_done), 32'd67);
        $display("frame 0x0C01 en_load=1 done_lat=%0d bits=0x%04h", r_done, r_bits);

        // Start while busy must not disturb the frame.
        run_frame(16'h0155, 1'b1, 1'b0, 10, r_done, r_lrise, r_bits, r_nrise, r_lrises, r_l1, r_err);
        chk("busy_start_bits", 32'(r_bits), 32'h0155);
        chk("busy_start_done_lat", 32'(r_done), 32'd67);
`ifdef MAX7219_SERIAL_IF_START_ERR_EN
        chk("busy_start_err_pulses", 32'(r_err), 32'd1);
`endif
        $display("frame 0x0155 with overlapping start done_lat=%0d bits=0x%04h", r_done, r_bits);

        // Daisy chain: unlatched frame then latched frame.
        run_frame(16'h0A0F, 1'b0, 1'b0, -1, r_done, r_lrise, r_bits, r_nrise, r_lrises, r_l1, r_err);
        chk("daisy1_bits", 32'(r_bits), 32'h0A0F);
        chk("daisy1_done_lat", 32'(r_done), 32'd65);
        chk("daisy1_load_rises", 32'(r_lrises), 32'd0);
        #1;
        chk("daisy1_load_after", 32'(d_load), 32'd0);
        $display("frame 0x0A0F en_load=0 done_lat=%0d bits=0x%04h", r_done, r_bits);
        run_frame(16'h0B07, 1'b1, 1'b0, -1, r_done, r_lrise, r_bits, r_nrise, r_lrises, r_l1, r_err);
        chk("daisy2_bits", 32'(r_bits), 32'h0B07);
        chk("daisy2_load_rises", 32'(r_lrises), 32'd1);
        chk("daisy2_load_rise_lat", 32'(r_lrise), 32'd67);
        chk("daisy2_done_lat", 32'(r_done), 32'd67);
        $display("frame 0x0B07 en_load=1 done_lat=%0d bits=0x%04h", r_done, r_bits);

        // Asynchronous reset mid-frame (CLK is high at this point).
        @(negedge clk);
        data = 16'h0C01; en_load = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (19) @(negedge clk);
        chk("pre_abort_busy", 32'(d_busy), 32'd1);
        rst = 1'b1;
        #1;
        chk("async_abort{clk,load,busy,done}", 32'({d_clk, d_load, d_busy, d_done}), 32'(4'b0100));
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("abort_no_done", 32'(d_done), 32'd0);
        run_frame(16'h0C01, 1'b1, 1'b0, -1, r_done, r_lrise, r_bits, r_nrise, r_lrises, r_l1, r_err);
        chk("post_abort_bits", 32'(r_bits), 32'h0C01);
        chk("post_abort_done_lat", 32'(r_done), 32'd67);
        $display("frame after abort done_lat=%0d bits=0x%04h", r_done, r_bits);

        // Disabled block ignores start.
        @(negedge clk);
        en = 1'b0; start = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("en0_busy", 32'(d_busy), 32'd0);
        end
        start = 1'b0; en = 1'b1;

        // H=1 instance latency.
        run_frame(16'h0F00, 1'b1, 1'b1, -1, r_done, r_lrise, r_bits, r_nrise, r_lrises, r_l1, r_err);
        chk("h1_bits", 32'(r_bits), 32'h0F00);
        chk("h1_done_lat", 32'(r_done), 32'd34);
        chk("h1_clk_rises", 32'(r_nrise), 32'd16);
        $display("H=1 frame 0x0F00 en_load=1 done_lat=%0d bits=0x%04h", r_done, r_bits);

        // Back-to-back requests with start held high.
        @(negedge clk);
        start = 1'b1; en = 1'b1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            data = 16'($urandom); en_load = 1'($urandom_range(0, 1));
        end
        start = 1'b0;

        // Randomized traffic, including occasional resets.
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            en      = ($urandom_range(0, 7) != 0);
            start   = ($urandom_range(0, 5) == 0);
            data    = 16'($urandom);
            en_load = 1'($urandom_range(0, 1));
            rst     = ($urandom_range(0, 399) == 0);
        end
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        repeat (3) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/max7219_serial_if.md
Name: max7219_serial_if

Overview:
- Physical-side serializer for the MAX7219 display driver.
- Accepts one 16-bit frame per start request from the command decoder, using `o_max7219_if_start`, `o_max7219_if_en_load` and `o_max7219_if_data`.
- Shifts the frame MSB-first on DIN/CLK and optionally raises LOAD to latch it.
- Returns a one-cycle done pulse.
- Sits between `max7219_cmd_decod` and the device pins; it is the responder end of the `max7219_if` handshake.

Parameters:
- G_HALF_PERIOD, 2, number of clk cycles per serial-clock half period (H); legal range ≥1.
- G_DATA_WIDTH, 16, frame width in bits; fixed by the MAX7219 protocol.

Ports:
- clk  in  1  system clock; one clock domain.
- rst  in  1  asynchronous, active-high reset.
- i_en  in  1  block enable; when 0, new starts are ignored.
- i_start  in  1  frame request; sampled only in IDLE.
- i_en_load  in  1  when 1, LOAD rises after this frame; latched with i_start.
- i_data  in  G_DATA_WIDTH  frame, [15:8] address and [7:0] data; latched with i_start.
- o_done  out  1  one-cycle pulse at frame end.
- o_busy  out  1  high whenever the FSM is not in IDLE.
- o_max7219_clk  out  1  serial clock to device.
- o_max7219_din  out  1  serial data to device.
- o_max7219_load  out  1  LOAD/CS to device.

Behaviour:
- Interface: one clock `clk`; reset `rst` is asynchronous and active-high.
- Reset values:
  - o_done=0, o_busy=0
  - o_max7219_clk=0, o_max7219_din=0, o_max7219_load=1
  - FSM=IDLE, shift register=0, bit index=G_DATA_WIDTH-1
- Reset mid-frame aborts immediately; all outputs take their reset values asynchronously.
- All outputs are registered.
- FSM states: IDLE, CLK_LOW, CLK_HIGH, LATCH, DONE.
- IDLE: if i_en=1 and i_start=1 at edge t0:
  - latch i_data and i_en_load;
  - load<=0, clk<=0, din<=i_data[15], index<=15;
  - go to CLK_LOW.
  - i_start is ignored when i_en=0.
- CLK_LOW: hold H cycles, then clk<=1 and go to CLK_HIGH. The device samples DIN on this rising edge.
- CLK_HIGH: hold H cycles, then clk<=0.
  - If index≠0: index--, din<=next bit, go to CLK_LOW.
  - If index=0: go to LATCH if the latched en_load=1, otherwise go to DONE.
- LATCH: hold load=0 for H cycles (LOAD hold after the last CLK fall), then load<=1 and go to DONE.
- DONE: o_done=1 for exactly one cycle, then go to IDLE.
- Without en_load, LOAD stays 0 in IDLE. This allows daisy-chained frames; the next frame with en_load=1 produces the latch edge.
- Latency: o_done is high on edge t0 + 32H + L + 1, where L=H if en_load=1, else 0.
  - H=2, en_load=1: 67 cycles.
  - H=2, en_load=0: 65 cycles.
- i_start while busy is ignored; the frame in progress is not disturbed.
- i_en falling mid-frame: the frame completes normally.
- Back-to-back operation: i_start held high during DONE is not accepted; it is accepted on the following IDLE cycle. Minimum frame period is 32H+L+2 cycles.
- A single counter (width clog2(G_HALF_PERIOD)) times both half-periods and the LATCH phase. It resets to 0 on every state entry.

Optional Feature:
- Macro: MAX7219_SERIAL_IF_START_ERR_EN.
- Defined: adds output port o_start_err (1 bit, reset 0). It pulses high for one cycle whenever i_start=1 while o_busy=1. It also pulses during DONE.
- Undefined: the port and its logic are absent; overlapping starts are silently ignored.

Decomposition:
- Package max7219_pkg holds:
  - state enum t_max7219_if_state;
  - C_MAX7219_FRAME_W=16;
  - register address constants: NOOP 0x0, DIGIT0..7 0x1–0x8, DECODE_MODE 0x9, INTENSITY 0xA, SCAN_LIMIT 0xB, SHUTDOWN 0xC, DISPLAY_TEST 0xF.
- One natural sub-module: max7219_half_period_cnt. It takes G_HALF_PERIOD, a restart input and a tick output, and is reused by the FSM for all timed phases.

Test Plan:
1. Reset, idle: assert rst with no start → load=1, clk=0, din=0, busy=0, done=0, and they hold.
2. Latched frame: H=2, i_data=0x0C01, en_load=1 → 16 CLK rising edges with DIN sampled as 0000_1100_0000_0001; LOAD falls at t0+1 and rises 2 cycles after the last CLK fall; done at t0+67.
3. Daisy chain: frame 0x0A0F with en_load=0, then 0x0B07 with en_load=1 → LOAD stays low across both frames; a single LOAD rise after the second frame; first done at t0+65.
4. Start while busy: pulse i_start at t0+10 with data 0xFFFF → ignored, and the serial stream still equals the first frame. With the macro defined, o_start_err pulses once at t0+11.
5. Async reset mid-frame: assert rst at t0+20 → clk=0, load=1, busy=0 within the same cycle; no done; the next start is accepted normally.
6. i_en=0 with i_start pulsed → no activity and busy stays 0. With H=1, 0x0F00 and en_load=1 → done at t0+34.
